// File: rtl/free_list_ctrl_pkg.sv
// Shared configuration for the physical-register free list: register-file
// geometry and the controller's state and scan-mode encodings.
package free_list_ctrl_pkg;

  localparam int PROJ_NUM_PHYS_REGS = 64;
  localparam int PROJ_LOG_PHYS      = 6;
  localparam int PROJ_NUM_ARCH_REGS = 32;

  // Controller state: rebuilding the list, or serving rename/commit.
  typedef enum logic {
    FL_SCAN = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_e;

  // Scan mode: INIT skips the identity-mapped architectural registers,
  // RECOVER skips whatever the retirement RAT still holds.
  typedef enum logic {
    FL_MODE_INIT    = 1'b0,
    FL_MODE_RECOVER = 1'b1
  } fl_mode_e;

endpackage

// File: rtl/free_list_fifo.sv
// Circular buffer of physical-register indices with head/tail/count
// tracking. Pops of an empty buffer and pushes into a full buffer (without
// a matching pop) are ignored; the caller decides what a dropped push means.
module free_list_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [AW-1:0] head_data_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [AW-1:0] mem [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Pointer increment with an explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem[head_q];

  // A push into a full buffer is allowed only when a pop frees the slot in
  // the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop)  head_d = ptr_inc(head_q);
    if (do_push) tail_d = ptr_inc(tail_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; clear empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; an entry is only ever read after
  // it has been written, and count_q alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list controller: hands one free physical register per cycle to
// rename, takes one released register per cycle from ROB commit, and
// rebuilds the list by scanning every physical index after reset or flush.
module free_list_ctrl
  import free_list_ctrl_pkg::*;
#(
  parameter int NUM_PHYS = PROJ_NUM_PHYS_REGS,
  parameter int LOG_PHYS = PROJ_LOG_PHYS,
  parameter int NUM_ARCH = PROJ_NUM_ARCH_REGS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Grab_IN,
  input  logic                Release_valid_IN,
  input  logic [LOG_PHYS-1:0] Release_reg_IN,
  input  logic                Flush_IN,
  input  logic [NUM_PHYS-1:0] Committed_map_IN,
  output logic [LOG_PHYS-1:0] Free_phys_reg,
  output logic                Free_reg_avail,
  output logic [LOG_PHYS:0]   Free_count,
  output logic                Recovering,
  output logic                Overflow_err
);

  fl_state_e           state_q, state_d;
  fl_mode_e            mode_q, mode_d;
  logic [LOG_PHYS-1:0] scan_idx_q, scan_idx_d;
  logic                overflow_q, overflow_d;

  logic                fifo_clear;
  logic                fifo_push;
  logic [LOG_PHYS-1:0] fifo_push_data;
  logic                fifo_pop;
  logic [LOG_PHYS-1:0] fifo_head;
  logic [LOG_PHYS:0]   fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  logic                scan_keep;
  logic                scan_last;
  logic                release_ok;

  free_list_fifo #(
    .DEPTH (NUM_PHYS),
    .AW    (LOG_PHYS)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RESET),
    .clear_i     (fifo_clear),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .head_data_o (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // INIT frees everything above the identity-mapped architectural range;
  // RECOVER frees whatever retirement does not hold, never phys reg 0.
  assign scan_keep = (mode_q == FL_MODE_INIT)
                   ? (scan_idx_q >= LOG_PHYS'(NUM_ARCH))
                   : ((scan_idx_q != '0) && !Committed_map_IN[scan_idx_q]);
  assign scan_last  = (scan_idx_q == LOG_PHYS'(NUM_PHYS - 1));
  assign release_ok = Release_valid_IN && (Release_reg_IN != '0);

  // Next-state logic: flush restarts a RECOVER scan from any state, SCAN
  // walks one index per cycle, RUN serves grabs and releases.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    scan_idx_d     = scan_idx_q;
    overflow_d     = overflow_q;
    fifo_clear     = 1'b0;
    fifo_push      = 1'b0;
    fifo_push_data = scan_idx_q;
    fifo_pop       = 1'b0;

    if (Flush_IN) begin
      state_d    = FL_SCAN;
      mode_d     = FL_MODE_RECOVER;
      scan_idx_d = '0;
      fifo_clear = 1'b1;
    end else begin
      case (state_q)
        FL_SCAN: begin
          fifo_push  = scan_keep;
          scan_idx_d = scan_last ? '0 : scan_idx_q + 1'b1;
          if (scan_last) state_d = FL_RUN;
        end
        FL_RUN: begin
          fifo_pop       = Grab_IN && !fifo_empty;
          fifo_push_data = Release_reg_IN;
          if (release_ok) begin
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
            else                        fifo_push  = 1'b1;
          end
        end
        default: state_d = FL_SCAN;
      endcase
    end
  end

  // Control registers; reset starts an INIT scan and clears the sticky error.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= FL_SCAN;
      mode_q     <= FL_MODE_INIT;
      scan_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      scan_idx_q <= scan_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign Free_phys_reg  = fifo_head;
  assign Free_reg_avail = (state_q == FL_RUN) && !fifo_empty;
  assign Free_count     = fifo_count;
  assign Recovering     = (state_q == FL_SCAN);
  assign Overflow_err   = overflow_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl. Stimulus pushes the register it
// expects each accepted grab to return; a monitor on the falling edge pops
// and compares on every grab handshake. State outputs are checked directly.
module tb_free_list_ctrl;

  logic        CLK;
  logic        RESET;
  logic        Grab_IN;
  logic        Release_valid_IN;
  logic [5:0]  Release_reg_IN;
  logic        Flush_IN;
  logic [63:0] Committed_map_IN;
  logic [5:0]  Free_phys_reg;
  logic        Free_reg_avail;
  logic [6:0]  Free_count;
  logic        Recovering;
  logic        Overflow_err;

  logic [5:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  free_list_ctrl dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Grab_IN          (Grab_IN),
    .Release_valid_IN (Release_valid_IN),
    .Release_reg_IN   (Release_reg_IN),
    .Flush_IN         (Flush_IN),
    .Committed_map_IN (Committed_map_IN),
    .Free_phys_reg    (Free_phys_reg),
    .Free_reg_avail   (Free_reg_avail),
    .Free_count       (Free_count),
    .Recovering       (Recovering),
    .Overflow_err     (Overflow_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just past it before driving/checking.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard monitor: every accepted grab must return the next expected register.
  always @(negedge CLK) begin
    if (RESET === 1'b1 && Grab_IN === 1'b1 && Free_reg_avail === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grab_unexpected: got reg %0d expected no grab accepted", Free_phys_reg);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (Free_phys_reg !== e) begin
          n_fail++;
          $display("FAIL grab_value: got %0d expected %0d", Free_phys_reg, e);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET            = 1'b0;
    Grab_IN          = 1'b0;
    Release_valid_IN = 1'b0;
    Release_reg_IN   = '0;
    Flush_IN         = 1'b0;
    Committed_map_IN = '0;

    // Reset held for two edges.
    run_cycles(2);
    check("reset_recovering", Recovering, 1);
    check("reset_avail", Free_reg_avail, 0);
    check("reset_count", Free_count, 0);
    check("reset_overflow", Overflow_err, 0);

    // INIT scan: edges 0..62 push idx 32..62, edge 63 pushes 63 and enters RUN.
    RESET = 1'b1;
    run_cycles(63);
    check("init_still_scanning", Recovering, 1);
    check("init_avail_in_scan", Free_reg_avail, 0);
    check("init_count_partial", Free_count, 31);
    step();
    check("init_run", Recovering, 0);
    check("init_avail", Free_reg_avail, 1);
    check("init_head", Free_phys_reg, 32);
    check("init_count", Free_count, 32);

    // Grab every cycle: 32..63, then empty; the 33rd grab is ignored.
    for (int i = 0; i < 32; i++) begin
      Grab_IN = 1'b1;
      exp_q.push_back(6'(32 + i));
      step();
    end
    check("drain_avail", Free_reg_avail, 0);
    check("drain_count", Free_count, 0);
    step();
    check("extra_grab_count", Free_count, 0);

    // Empty list: grab plus release of 40 -> grab ignored, no bypass.
    Release_valid_IN = 1'b1;
    Release_reg_IN   = 6'd40;
    step();
    Grab_IN          = 1'b0;
    Release_valid_IN = 1'b0;
    check("empty_grab_rel_count", Free_count, 1);
    check("empty_grab_rel_avail", Free_reg_avail, 1);
    check("empty_grab_rel_head", Free_phys_reg, 40);

    // Releasing phys reg 0 is ignored.
    Release_valid_IN = 1'b1;
    Release_reg_IN   = 6'd0;
    step();
    Release_valid_IN = 1'b0;
    check("release_zero_count", Free_count, 1);

    // Release 45, then grab+release 50 with a non-empty list: count unchanged.
    Release_valid_IN = 1'b1;
    Release_reg_IN   = 6'd45;
    step();
    check("release45_count", Free_count, 2);
    Grab_IN = 1'b1;
    exp_q.push_back(6'd40);
    Release_reg_IN = 6'd50;
    step();
    Release_valid_IN = 1'b0;
    check("grab_rel_count", Free_count, 2);
    exp_q.push_back(6'd45);
    exp_q.push_back(6'd50);
    run_cycles(2);
    Grab_IN = 1'b0;
    check("grab_rel_drained", Free_count, 0);

    // Flush with the retirement map holding 0 and 32..63 -> list is 1..31.
    Committed_map_IN = {32'hFFFF_FFFF, 32'h0000_0001};
    Flush_IN = 1'b1;
    Grab_IN  = 1'b1;
    step();
    Flush_IN = 1'b0;
    Grab_IN  = 1'b0;
    check("flush_recovering", Recovering, 1);
    check("flush_avail", Free_reg_avail, 0);
    check("flush_count", Free_count, 0);
    run_cycles(63);
    check("recover_still_scanning", Recovering, 1);
    step();
    check("recover_run", Recovering, 0);
    check("recover_count", Free_count, 31);
    for (int i = 1; i <= 31; i++) begin
      Grab_IN = 1'b1;
      exp_q.push_back(6'(i));
      step();
    end
    Grab_IN = 1'b0;
    check("recover_drained", Free_count, 0);

    // Flush, then flush again at scan idx 20: the scan restarts.
    Flush_IN = 1'b1;
    step();
    Flush_IN = 1'b0;
    run_cycles(20);
    check("midscan_count_before", Free_count, 19);
    Flush_IN = 1'b1;
    step();
    Flush_IN = 1'b0;
    check("midscan_restart_count", Free_count, 0);
    check("midscan_recovering", Recovering, 1);
    run_cycles(63);
    check("midscan_still_scanning", Recovering, 1);
    step();
    check("midscan_run", Recovering, 0);
    check("midscan_count", Free_count, 31);
    check("midscan_head", Free_phys_reg, 1);

    // Fill: RECOVER with only bit 0 held gives 63 entries, one release -> 64.
    Committed_map_IN = 64'h1;
    Flush_IN = 1'b1;
    step();
    Flush_IN = 1'b0;
    run_cycles(64);
    check("full_scan_count", Free_count, 63);
    Release_valid_IN = 1'b1;
    Release_reg_IN   = 6'd7;
    step();
    check("full_count", Free_count, 64);
    check("full_no_overflow", Overflow_err, 0);
    Release_reg_IN = 6'd9;
    step();
    check("overflow_set", Overflow_err, 1);
    check("overflow_count", Free_count, 64);
    // Full with grab and release together: both take effect.
    Grab_IN = 1'b1;
    exp_q.push_back(6'd1);
    step();
    Grab_IN          = 1'b0;
    Release_valid_IN = 1'b0;
    check("full_grab_rel_count", Free_count, 64);
    check("full_grab_rel_head", Free_phys_reg, 2);

    // Overflow stays set through a flush and clears only on reset.
    Flush_IN = 1'b1;
    step();
    Flush_IN = 1'b0;
    check("overflow_after_flush", Overflow_err, 1);
    check("flush2_count", Free_count, 0);
    run_cycles(5);
    RESET = 1'b0;
    step();
    check("overflow_cleared", Overflow_err, 0);
    check("reset2_recovering", Recovering, 1);
    check("reset2_count", Free_count, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
